// File: rtl/clk_enable_scheduler.sv
// Round-robin scheduler that lends one programmable tick generator to N requesters,
// issuing a burst of single-cycle clock-enable strobes to the current owner.
module clk_enable_scheduler #(
    parameter int unsigned N  = 4,
    parameter int unsigned LW = 8,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*LW-1:0] req_len,
    input  logic [DW-1:0]   div,
    output logic [N-1:0]    grant,
    output logic [N-1:0]    ce,
    output logic [N-1:0]    done,
    output logic            aborted,
    output logic            busy
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   per_q, per_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   left_q, left_d;
    logic            aborted_q, aborted_d;

    logic            found;
    logic [IW-1:0]   pick;
    int unsigned     j;
    logic            ce_due;
    logic [N-1:0]    owner_oh;

    // First active request at or after the round-robin pointer, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_q) + k) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    assign ce_due   = (state_q == StRun) && (cnt_q == per_q - DW'(1));
    assign owner_oh = N'(1) << idx_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        per_d     = per_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        aborted_d = aborted_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    idx_d     = pick;
                    per_d     = (div == '0) ? DW'(1) : div;
                    left_d    = req_len[pick*LW +: LW];
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = (req_len[pick*LW +: LW] == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                cnt_d = ce_due ? '0 : cnt_q + DW'(1);
                if (ce_due) begin
                    left_d = left_q - LW'(1);
                end
                // A strobe due in the same cycle as a dropped request still counts.
                if (ce_due && left_q == LW'(1)) begin
                    state_d   = StDone;
                    aborted_d = 1'b0;
                end else if (!req[idx_q]) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                ptr_d   = (32'(idx_q) == N - 1) ? '0 : idx_q + IW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            ptr_q     <= '0;
            per_q     <= DW'(1);
            cnt_q     <= '0;
            left_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            aborted_q <= aborted_d;
        end
    end

    assign grant   = (state_q != StIdle) ? owner_oh : '0;
    assign ce      = ce_due ? owner_oh : '0;
    assign done    = (state_q == StDone) ? owner_oh : '0;
    assign aborted = (state_q == StDone) && aborted_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Bench for clk_enable_scheduler: burst-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_clk_enable_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned LW = 8;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [DW-1:0]   div = '0;
    logic [N-1:0]    grant, ce, done;
    logic            aborted, busy;

    int n_vec = 0;
    int n_bad = 0;

    clk_enable_scheduler #(.N(N), .LW(LW), .DW(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_len (req_len),
        .div     (div),
        .grant   (grant),
        .ce      (ce),
        .done    (done),
        .aborted (aborted),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Burst-level model: phase 0 idle, 1 serving, 2 finishing.
    int m_phase, m_owner, m_p, m_left, m_age, m_ptr;
    bit m_ab;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_owner = 0; m_ptr = 0; m_ab = 0;
            m_p = 1; m_left = 0; m_age = 0;
        end else begin
            case (m_phase)
                0: if (req != '0) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                    m_p     = (div == 0) ? 1 : int'(div);
                    m_left  = int'((req_len >> (m_owner * LW)) & 32'hFF);
                    m_age   = 0;
                    m_ab    = 0;
                    m_phase = (m_left == 0) ? 2 : 1;
                end
                1: begin
                    bit strobe;
                    strobe = ((m_age + 1) % m_p) == 0;
                    if (strobe) m_left--;
                    if (strobe && m_left == 0) begin
                        m_phase = 2; m_ab = 0;
                    end else if (!req[m_owner]) begin
                        m_phase = 2; m_ab = 1;
                    end else begin
                        m_age++;
                    end
                end
                default: begin
                    m_phase = 0;
                    m_ptr   = (m_owner + 1) % N;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            logic [N-1:0] oh;
            oh = N'(1) << m_owner;
            chk("model.grant", 32'(grant), 32'((m_phase != 0) ? oh : '0));
            chk("model.ce", 32'(ce),
                32'((m_phase == 1 && ((m_age + 1) % m_p) == 0) ? oh : '0));
            chk("model.done", 32'(done), 32'((m_phase == 2) ? oh : '0));
            chk("model.aborted", 32'(aborted), 32'(m_phase == 2 && m_ab));
            chk("model.busy", 32'(busy), 32'(m_phase != 0));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_len(input int i, input int len);
        req_len[i*LW +: LW] = LW'(len);
    endtask

    initial begin
        // Reset state
        #2;
        chk("reset.grant", 32'(grant), 0);
        chk("reset.busy", 32'(busy), 0);
        do_reset();

        // Single burst: len 3, div 2 -> ce on 2,4,6, done 7, idle 8
        set_len(0, 3); div = 2; req = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("single.grant", 32'(grant[0]), 32'(k <= 7));
            chk("single.ce", 32'(ce[0]), 32'(k == 2 || k == 4 || k == 6));
            chk("single.done", 32'(done[0]), 32'(k == 7));
            if (k == 7) begin
                chk("single.aborted", 32'(aborted), 0);
                req = '0;
            end
        end

        // div 0 and div 1: four consecutive strobes from the grant cycle
        for (int d = 0; d <= 1; d++) begin
            set_len(0, 4); div = DW'(d); req = 4'b0001;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                chk("fast.ce", 32'(ce), 32'((k <= 4) ? 4'b0001 : 4'b0000));
                chk("fast.done", 32'(done), 32'((k == 5) ? 4'b0001 : 4'b0000));
                if (k == 5) req = '0;
            end
        end

        // Round-robin fairness from ptr 0
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 1);
        div = 1; req = 4'b1111;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1)  chk("rr.g0", 32'(grant), 32'h1);
            if (k == 4)  chk("rr.g1", 32'(grant), 32'h2);
            if (k == 7)  chk("rr.g2", 32'(grant), 32'h4);
            if (k == 10) chk("rr.g3", 32'(grant), 32'h8);
            if (k == 13) begin
                chk("rr.g0again", 32'(grant), 32'h1);
                req = '0;
            end
        end
        repeat (2) @(negedge clk);

        // Zero length on requester 2: grant and done together, no strobe
        do_reset();
        set_len(2, 0); req = 4'b0100;
        @(negedge clk);
        chk("zero.grant", 32'(grant), 32'h4);
        chk("zero.done", 32'(done), 32'h4);
        chk("zero.ce", 32'(ce), 0);
        req = '0;
        repeat (2) @(negedge clk);

        // div changed mid-burst: spacing stays 3
        set_len(0, 2); div = 3; req = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) div = 1;
            chk("middiv.ce", 32'(ce[0]), 32'(k == 3 || k == 6));
            chk("middiv.done", 32'(done[0]), 32'(k == 7));
            if (k == 7) req = '0;
        end

        // Abort after 4th strobe of 10
        set_len(0, 10); div = 1; req = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("abort.ce", 32'(ce[0]), 32'(k <= 4));
            if (k == 4) req = '0;
            if (k == 5) begin
                chk("abort.done", 32'(done[0]), 1);
                chk("abort.aborted", 32'(aborted), 1);
            end
        end

        // Drop coinciding with the final strobe is a normal completion
        set_len(0, 3); req = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) req = '0;
            if (k == 4) begin
                chk("lastdrop.done", 32'(done[0]), 1);
                chk("lastdrop.aborted", 32'(aborted), 0);
            end
        end

        // Asynchronous reset mid-burst on requester 1 (ptr is 1 here)
        set_len(1, 10); div = 1; req = 4'b0010;
        repeat (3) @(negedge clk);
        chk("prereset.grant", 32'(grant), 32'h2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async.grant", 32'(grant), 0);
        chk("async.ce", 32'(ce), 0);
        chk("async.done", 32'(done), 0);
        chk("async.busy", 32'(busy), 0);
        set_len(0, 1);
        req = 4'b0011;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postreset.grant", 32'(grant), 32'h1);
        req = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
